// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: owns PC/A/D/IR, sequences FETCH/DECODE/EXEC,
// drives the external ALU and resolves writeback, memory writes and jumps.
module hack_cpu_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] retired_q, retired_d;
    logic        jump_taken;

    // ALU controls and operands come straight from IR in every state.
    assign alu_zx = ir_q[11];
    assign alu_nx = ir_q[10];
    assign alu_zy = ir_q[9];
    assign alu_ny = ir_q[8];
    assign alu_f  = ir_q[7];
    assign alu_no = ir_q[6];
    assign alu_x  = d_q;
    assign alu_y  = ir_q[12] ? mem_rdata : a_q;

    assign rom_addr  = pc_q;
    assign mem_addr  = a_q[14:0];
    assign mem_wdata = alu_out;
    assign mem_we    = (state_q == ST_EXEC) & ir_q[3] & ~rst;

    assign pc      = pc_q;
    assign a_reg   = a_q;
    assign d_reg   = d_q;
    assign retired = retired_q;

    assign jump_taken = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_zr & ~alu_ng);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        d_d       = d_q;
        ir_d      = ir_q;
        retired_d = retired_q;

        unique case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d = rom_data;
                if (!rom_data[15]) begin
                    a_d       = rom_data;
                    pc_d      = pc_q + 15'd1;
                    retired_d = retired_q + 16'd1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ir_q[5]) a_d = alu_out;
                if (ir_q[4]) d_d = alu_out;
                // Jump target is the A value before this edge, even when A is also a destination.
                pc_d      = jump_taken ? a_q[14:0] : pc_q + 15'd1;
                retired_d = retired_q + 16'd1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            d_q       <= d_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack CPU control and datapath registers. Sits directly upstream of the ALU instance and drives its x/y operands and six control bits. Consumes the ALU result and zr/ng flags to write back A, D and data memory and to resolve jumps. Also fetches instructions from a synchronous instruction ROM and owns the PC.

## Interface
- No parameters (widths fixed: 16-bit data, 15-bit addresses).
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  15  instruction address (= PC)
- rom_data  in  16  instruction word; valid one cycle after rom_addr changes
- mem_addr  out  15  data address (= A[14:0], continuous)
- mem_rdata  in  16  data read; valid one cycle after mem_addr changes
- mem_wdata  out  16  = alu_out
- mem_we  out  1  data write enable; memory writes on the same rising edge
- alu_x, alu_y  out  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control
- alu_out  in  16  ALU result (combinational from alu_x/alu_y/controls)
- alu_zr, alu_ng  in  1  ALU zero / negative flags
- pc  out  15  current PC
- a_reg, d_reg  out  16  A and D registers (debug/verif)
- retired  out  16  retired-instruction count

## Operation
- Registers: PC[14:0], A[15:0], D[15:0], IR[15:0], state, retired[15:0].
- FSM states:
  - FETCH: rom_addr = PC. Next state is DECODE.
  - DECODE: IR <= rom_data.
    - If rom_data[15]=0 (A-instr): A <= rom_data, PC <= PC+1, retired += 1, next state FETCH.
    - Else next state is EXEC.
  - EXEC: executes the C-instruction in IR. Next state is FETCH.
- Controls are driven from IR in every state:
  - zx=IR[11], nx=IR[10], zy=IR[9], ny=IR[8], f=IR[7], no=IR[6].
  - alu_x = D; alu_y = IR[12] ? mem_rdata : A.
- Destinations in EXEC:
  - d1=IR[5]: A <= alu_out.
  - d2=IR[4]: D <= alu_out.
  - d3=IR[3]: mem_we=1, with mem_addr = A before this edge.
- mem_we = (state==EXEC) & IR[3] & ~rst. It is 0 in all other states.
- Jump in EXEC: taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~zr&~ng).
  - Taken: PC <= A[14:0], the pre-edge A, even if d1 rewrites A.
  - Not taken: PC <= PC+1.
  - retired += 1.
- Arithmetic and width:
  - PC+1 wraps 0x7FFF -> 0x0000.
  - retired wraps 0xFFFF -> 0x0000.
  - A-instr value loads all 16 bits; bit 15 is 0.
  - IR[14:13] are ignored.
- Simultaneous destinations:
  - AMD all apply on the same edge, with the same alu_out.
  - M uses the old address.

## Timing
- Reset values: PC=0, A=0, D=0, IR=0, retired=0, state=FETCH, mem_we=0.
  - Output values under reset: rom_addr=0, mem_addr=0, alu_x=0.
  - alu_y=0, and all ALU controls 0 (IR=0).
- rst asserted in any state, including EXEC with IR[3]=1:
  - No register or memory update occurs on that edge.
  - mem_we is forced 0.
- Latency:
  - A-instr: 2 cycles (FETCH, DECODE).
  - C-instr: 3 cycles (FETCH, DECODE, EXEC).
- mem_rdata validity: A changes only at the end of DECODE or EXEC. mem_addr is therefore stable for ≥2 cycles before any EXEC, so mem_rdata is valid in EXEC without a wait state.
- The memory must hold mem_rdata for a stable address.
- First fetch after rst deasserts is rom_addr=0.

## Test plan
- Reset/A-load:
  - Stimulus: hold rst 3 cycles, then ROM[0]=0x0005.
  - Required: all outputs at reset values during rst.
  - Required: A=5, PC=1, retired=1 exactly 2 cycles after rst falls.
- D=A, D=D+A:
  - Stimulus: ROM = 0x0005, 0xEC10, 0x0003, 0xE090.
  - Required: D=8, PC=4, retired=4 after 10 cycles.
- M=D write:
  - Stimulus: ROM = 0x0007, 0xEC10, 0x0064, 0xE308.
  - Required: mem_we high for exactly one cycle, with mem_addr=100 and mem_wdata=7.
- AM=M+1:
  - Stimulus: mem[9]=41; ROM = 0x0009, 0xFDE8.
  - Required: on the EXEC edge, mem[9]<=42 (write at old A=9) and A=42.
- Jumps:
  - Stimulus: D=0 and A=0x0010, then execute D;JEQ (0xE302).
  - Required: PC=0x10.
  - Stimulus: same with D=1.
  - Required: PC increments.
  - Stimulus: 0;JMP (0xEA87) with A=0x7FFF.
  - Required: PC=0x7FFF; an A-instr there wraps PC to 0.
- Reset mid-EXEC:
  - Stimulus: assert rst during the EXEC cycle of M=D.
  - Required: mem_we=0 and memory unchanged.
  - Required: PC=0, A=0, D=0, state FETCH next cycle.
